rx_ctrl: RTL and testbench
==========================

RX_CTRL -- requirements
Module: rx_ctrl

Interface
REQ-001 Parameter MAX_BYTES, default 64, maximum data bytes accepted per packet after SYNC (range 1..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 d_edge  input  1  one-cycle pulse: D+ transition detected by the edge detector.
REQ-005 shift_enable  input  1  one-cycle pulse at each bit sample point.
REQ-006 eop  input  1  end-of-packet line state (SE0) present; valid when sampled with shift_enable.
REQ-007 byte_received  input  1  one-cycle pulse: 8 bits shifted, rcv_data valid this cycle.
REQ-008 rcv_data  input  8  most recently assembled byte.
REQ-009 rcving  output  1  high while a packet is in progress, i.e. from SYNC detection start to end-of-EOP edge.
REQ-010 w_enable  output  1  one-cycle pulse: write rcv_data (latched copy) to RX FIFO.
REQ-011 r_error  output  1  sticky packet error flag; held until the next packet starts.
REQ-012 wr_data  output  8  byte to write; valid while w_enable=1.

Function
REQ-013 FSM states SHALL be: IDLE, SYNC_WAIT, SYNC_CHECK, DATA_WAIT, STORE, EOP_GOOD, ERR_WAIT_EOP, EOP_ERR, ERR_IDLE.
REQ-014 All outputs SHALL be registered or decoded solely from registered state (no input-to-output combinational path).
REQ-015 IDLE / ERR_IDLE: d_edge -> SYNC_WAIT; r_error cleared to 0 on that same transition; byte counter cleared to 0.
REQ-016 SYNC_WAIT: eop&shift_enable -> ERR_WAIT_EOP bypassed, go EOP_ERR; else byte_received -> SYNC_CHECK with rcv_data latched.
REQ-017 SYNC_CHECK (one cycle): latched byte == 8'h80 -> DATA_WAIT; otherwise -> ERR_WAIT_EOP.
REQ-018 DATA_WAIT: partial-byte flag set on shift_enable, cleared on byte_received.
REQ-019 DATA_WAIT: eop&shift_enable with partial flag clear -> EOP_GOOD; with partial flag set -> EOP_ERR.
REQ-020 DATA_WAIT: byte_received with count < MAX_BYTES -> STORE, rcv_data latched into wr_data; with count == MAX_BYTES -> ERR_WAIT_EOP, no write.
REQ-021 Simultaneous eop&shift_enable and byte_received in DATA_WAIT: eop takes priority, byte discarded, -> EOP_ERR.
REQ-022 STORE (one cycle): w_enable=1, count increments by 1 (8-bit, saturates, never wraps), then -> DATA_WAIT.
REQ-023 ERR_WAIT_EOP: ignores byte_received; eop&shift_enable -> EOP_ERR.
REQ-024 EOP_GOOD: d_edge -> IDLE. EOP_ERR: d_edge -> ERR_IDLE.
REQ-025 r_error SHALL be set to 1 on any entry to ERR_WAIT_EOP or EOP_ERR.
REQ-026 rcving=1 in SYNC_WAIT, SYNC_CHECK, DATA_WAIT, STORE, EOP_GOOD, ERR_WAIT_EOP, EOP_ERR; 0 in IDLE and ERR_IDLE.
REQ-027 w_enable SHALL be 1 only in STORE; at most one pulse per received byte.

Reset
REQ-028 n_rst low SHALL immediately force state IDLE, rcving=0, w_enable=0, r_error=0, wr_data=8'h00, count=0, partial flag=0.
REQ-029 Reset asserted mid-packet SHALL abort the packet with no further w_enable; after release the block waits for d_edge in IDLE.

Verification
REQ-030 Good packet: edge, SYNC 8'h80, bytes 8'hA5, 8'h3C, EOP at byte boundary, edge -> two w_enable pulses with wr_data A5 then 3C, r_error=0, rcving falls one cycle after final edge.
REQ-031 Bad SYNC: edge, byte 8'h81, EOP, edge -> no w_enable, r_error=1 from cycle after SYNC_CHECK, state ERR_IDLE; next edge clears r_error to 0.
REQ-032 Early EOP: SYNC ok, 3 shift_enable pulses of a data byte then eop&shift_enable -> r_error=1, no w_enable for the partial byte.
REQ-033 Overflow with MAX_BYTES=2: SYNC, 3 data bytes, EOP -> exactly two w_enable pulses, r_error=1 on third byte_received.
REQ-034 Collision: byte_received coincident with eop&shift_enable in DATA_WAIT -> no write, r_error=1, EOP_ERR.
REQ-035 Reset mid-packet after first data byte: n_rst low for 2 cycles -> all outputs 0 asynchronously; a subsequent good packet is received correctly.

Source files
------------

// File: rtl/rx_ctrl.sv
// Receive-side packet controller: validates the SYNC byte and writes data
// bytes to the RX FIFO. It flags framing, partial-byte and overflow errors,
// and tracks whether a packet is in progress.
module rx_ctrl #(
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_enable,
  input  logic       eop,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHECK,
    DATA_WAIT,
    STORE,
    EOP_GOOD,
    ERR_WAIT_EOP,
    EOP_ERR,
    ERR_IDLE
  } state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [7:0] MAX_CNT      = 8'(MAX_BYTES);

  state_t     state;
  logic [7:0] count;
  logic [7:0] sync_byte;
  logic       partial;
  logic       eop_sample;

  // EOP is only meaningful at a bit sample point.
  assign eop_sample = eop & shift_enable;

  // Packet FSM. All outputs are registered and are updated on the transition into a state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      rcving    <= 1'b0;
      w_enable  <= 1'b0;
      r_error   <= 1'b0;
      wr_data   <= 8'h00;
      count     <= 8'h00;
      sync_byte <= 8'h00;
      partial   <= 1'b0;
    end else begin
      w_enable <= 1'b0;
      case (state)
        IDLE, ERR_IDLE: begin
          if (d_edge) begin
            state   <= SYNC_WAIT;
            rcving  <= 1'b1;
            r_error <= 1'b0;
            count   <= 8'h00;
            partial <= 1'b0;
          end
        end
        SYNC_WAIT: begin
          if (eop_sample) begin
            state   <= EOP_ERR;
            r_error <= 1'b1;
          end else if (byte_received) begin
            state     <= SYNC_CHECK;
            sync_byte <= rcv_data;
          end
        end
        SYNC_CHECK: begin
          if (sync_byte == SYNC_PATTERN) begin
            state   <= DATA_WAIT;
            partial <= 1'b0;
          end else begin
            state   <= ERR_WAIT_EOP;
            r_error <= 1'b1;
          end
        end
        DATA_WAIT: begin
          if (eop_sample) begin
            // A byte completing in the same cycle as EOP is discarded and treated as an error.
            if (partial || byte_received) begin
              state   <= EOP_ERR;
              r_error <= 1'b1;
            end else begin
              state <= EOP_GOOD;
            end
          end else if (byte_received) begin
            partial <= 1'b0;
            if (count < MAX_CNT) begin
              state    <= STORE;
              wr_data  <= rcv_data;
              w_enable <= 1'b1;
            end else begin
              state   <= ERR_WAIT_EOP;
              r_error <= 1'b1;
            end
          end else if (shift_enable) begin
            partial <= 1'b1;
          end
        end
        STORE: begin
          if (count != 8'hFF) begin
            count <= count + 8'd1;
          end
          state <= DATA_WAIT;
        end
        ERR_WAIT_EOP: begin
          if (eop_sample) begin
            state   <= EOP_ERR;
            r_error <= 1'b1;
          end
        end
        EOP_GOOD: begin
          if (d_edge) begin
            state  <= IDLE;
            rcving <= 1'b0;
          end
        end
        EOP_ERR: begin
          if (d_edge) begin
            state  <= ERR_IDLE;
            rcving <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          rcving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ctrl.sv
// Testbench for rx_ctrl. Packets are described by the SYNC byte, the data
// bytes, the trailing partial bits and collision. A packet-level model
// predicts the FIFO writes and the error flag from these fields.
module tb_rx_ctrl;

  localparam int MAXB = 2;

  logic       clk;
  logic       n_rst;
  logic       d_edge;
  logic       shift_enable;
  logic       eop;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [7:0] wr_data;

  int checks;
  int errors;

  logic [7:0] got_q[$];
  logic [7:0] pkt_bytes[0:7];

  rx_ctrl #(.MAX_BYTES(MAXB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .shift_enable (shift_enable),
    .eop          (eop),
    .byte_received(byte_received),
    .rcv_data     (rcv_data),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error),
    .wr_data      (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every FIFO write, sampled away from the active edge.
  always @(negedge clk) begin
    if (w_enable) got_q.push_back(wr_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit de, input bit se, input bit ep, input bit br, input logic [7:0] d);
    d_edge        = de;
    shift_enable  = se;
    eop           = ep;
    byte_received = br;
    rcv_data      = d;
    @(posedge clk);
    #1;
    d_edge        = 1'b0;
    shift_enable  = 1'b0;
    eop           = 1'b0;
    byte_received = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, rcv_data);
  endtask

  task automatic send_bits(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(0, 1, 0, 0, rcv_data);
      idle();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(8);
    cyc(0, 0, 0, 1, b);
    idle();
    idle();
  endtask

  // One packet: start edge, sync, n data bytes, optional partial bits or
  // collision, EOP, closing edge. Predicts writes and error at packet level.
  task automatic do_packet(input logic [7:0] sync, input int n, input int part, input bit coll);
    logic [7:0] exp_q[$];
    bit         good_sync;
    bit         exp_err;
    int         m;
    good_sync = (sync == 8'h80);
    exp_q.delete();
    if (good_sync) begin
      for (int i = 0; i < n && i < MAXB; i++) exp_q.push_back(pkt_bytes[i]);
    end
    exp_err = !good_sync || (n > MAXB) || (part > 0) || coll;

    got_q.delete();
    cyc(1, 0, 0, 0, rcv_data);
    check_eq("start_rcving", 32'(rcving), 32'd1);
    check_eq("start_rerr_clr", 32'(r_error), 32'd0);
    send_byte(sync);
    check_eq("sync_rerr", 32'(r_error), 32'(!good_sync));
    for (int i = 0; i < n; i++) begin
      send_byte(pkt_bytes[i]);
      check_eq("byte_rerr", 32'(r_error), 32'(!good_sync || (i >= MAXB)));
    end
    if (coll) begin
      send_bits(8);
      cyc(0, 1, 1, 1, 8'($urandom));
    end else begin
      send_bits(part);
      cyc(0, 1, 1, 0, rcv_data);
    end
    idle();
    check_eq("eop_rcving", 32'(rcving), 32'd1);
    check_eq("eop_rerr", 32'(r_error), 32'(exp_err));
    cyc(1, 0, 0, 0, rcv_data);
    check_eq("end_rcving", 32'(rcving), 32'd0);
    check_eq("end_rerr", 32'(r_error), 32'(exp_err));
    idle();
    check_eq("nwrites", 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check_eq("wr_data", 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [7:0] s;
    int         n;
    int         part;
    bit         coll;
    checks        = 0;
    errors        = 0;
    n_rst         = 1'b0;
    d_edge        = 1'b0;
    shift_enable  = 1'b0;
    eop           = 1'b0;
    byte_received = 1'b0;
    rcv_data      = 8'h00;
    #1;
    check_eq("rst_rcving", 32'(rcving), 32'd0);
    check_eq("rst_wen", 32'(w_enable), 32'd0);
    check_eq("rst_rerr", 32'(r_error), 32'd0);
    check_eq("rst_wrdata", 32'(wr_data), 32'd0);
    @(posedge clk);
    #2 n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Good packet with A5, 3C.
    pkt_bytes[0] = 8'hA5;
    pkt_bytes[1] = 8'h3C;
    do_packet(8'h80, 2, 0, 0);
    // Bad sync, then a good packet clears the error on its start edge.
    do_packet(8'h81, 0, 0, 0);
    do_packet(8'h80, 1, 0, 0);
    // Early EOP after 3 bits of a data byte.
    do_packet(8'h80, 1, 3, 0);
    // Overflow: three data bytes with MAX_BYTES of 2.
    pkt_bytes[2] = 8'h77;
    do_packet(8'h80, 3, 0, 0);
    // Collision of byte_received with EOP.
    do_packet(8'h80, 1, 0, 1);

    // EOP while still waiting for the sync byte.
    cyc(1, 0, 0, 0, rcv_data);
    send_bits(2);
    cyc(0, 1, 1, 0, rcv_data);
    idle();
    check_eq("syncwait_eop_rerr", 32'(r_error), 32'd1);
    cyc(1, 0, 0, 0, rcv_data);
    check_eq("syncwait_eop_rcving", 32'(rcving), 32'd0);

    // Reset mid-packet after the first data byte.
    cyc(1, 0, 0, 0, rcv_data);
    send_byte(8'h80);
    send_byte(8'h5A);
    got_q.delete();
    send_bits(3);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check_eq("midrst_rcving", 32'(rcving), 32'd0);
    check_eq("midrst_wen", 32'(w_enable), 32'd0);
    check_eq("midrst_rerr", 32'(r_error), 32'd0);
    check_eq("midrst_wrdata", 32'(wr_data), 32'd0);
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
    byte_received = 1'b1;
    rcv_data      = 8'h99;
    @(posedge clk);
    #1;
    byte_received = 1'b0;
    idle();
    check_eq("postrst_rcving", 32'(rcving), 32'd0);
    check_eq("postrst_nwrites", 32'(got_q.size()), 32'd0);
    pkt_bytes[0] = 8'h11;
    pkt_bytes[1] = 8'hEE;
    do_packet(8'h80, 2, 0, 0);

    // Randomized packets.
    for (int t = 0; t < 40; t++) begin
      s    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80;
      n    = $urandom_range(0, 4);
      part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      coll = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 8; i++) pkt_bytes[i] = 8'($urandom);
      do_packet(s, n, part, coll);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
